// File: rtl/multi_deque.sv
// multi_deque: CHANNELS independent double-ended queues of WORDS x WIDTH that share
// one command/data port. Each cycle runs at most one operation on the channel named
// by channel_select. All status outputs describe the channel registered in sel_q.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   channel_select    channel addressed by this cycle's operation
//   push_front/back   write data_in ahead of the front / behind the back
//   pop_front/back    discard the front / back entry
//   data_in           push data
//   data_front/back   front/back entry of the status channel (0 when empty)
//   count/empty/full  occupancy of the status channel
//   err               (only with DEQUE_ERR_FLAGS_EN) sticky per-channel flag for
//                     pushes requested while full or pops requested while empty
//
// Optional feature macro: DEQUE_ERR_FLAGS_EN
module multi_deque #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned WORDS    = 16,
    parameter int unsigned CHANNELS = 2,
    localparam int unsigned CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned PTR_BITS = $clog2(WORDS),
    localparam int unsigned CNT_BITS = $clog2(WORDS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH_BITS-1:0]  channel_select,
    input  logic                push_front,
    input  logic                push_back,
    input  logic                pop_front,
    input  logic                pop_back,
    input  logic [WIDTH-1:0]    data_in,
    output logic [WIDTH-1:0]    data_front,
    output logic [WIDTH-1:0]    data_back,
    output logic [CNT_BITS-1:0] count,
    output logic                empty,
`ifdef DEQUE_ERR_FLAGS_EN
    output logic [CHANNELS-1:0] err,
`endif
    output logic                full
);

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH_BACK,
        OP_PUSH_FRONT,
        OP_POP_BACK,
        OP_POP_FRONT
    } op_e;

    logic [PTR_BITS-1:0] head_q [CHANNELS];
    logic [PTR_BITS-1:0] head_d [CHANNELS];
    logic [CNT_BITS-1:0] cnt_q  [CHANNELS];
    logic [CNT_BITS-1:0] cnt_d  [CHANNELS];
    logic [CH_BITS-1:0]  sel_q;
    logic [CH_BITS-1:0]  sel_d;
    logic [WIDTH-1:0]    mem_q  [CHANNELS][WORDS];

    op_e                 op_c;
    logic                op_ch_valid_c;
    logic [PTR_BITS-1:0] cur_head_c;
    logic [CNT_BITS-1:0] cur_cnt_c;
    logic                can_push_c;
    logic                can_pop_c;
    logic                wr_en_c;
    logic [PTR_BITS-1:0] wr_addr_c;

    logic                sel_valid_c;
    logic [PTR_BITS-1:0] s_head_c;
    logic [CNT_BITS-1:0] s_cnt_c;
    logic [PTR_BITS-1:0] s_back_c;

    // Pick the highest-priority request that is legal for the addressed channel.
    always_comb begin
        op_c          = OP_NONE;
        cur_head_c    = '0;
        cur_cnt_c     = '0;
        op_ch_valid_c = ({1'b0, channel_select} < (CH_BITS + 1)'(CHANNELS));
        if (op_ch_valid_c) begin
            cur_head_c = head_q[channel_select];
            cur_cnt_c  = cnt_q[channel_select];
        end
        can_push_c = (cur_cnt_c != CNT_BITS'(WORDS));
        can_pop_c  = (cur_cnt_c != '0);
        if (op_ch_valid_c) begin
            if (push_back && can_push_c) begin
                op_c = OP_PUSH_BACK;
            end else if (push_front && can_push_c) begin
                op_c = OP_PUSH_FRONT;
            end else if (pop_back && can_pop_c) begin
                op_c = OP_POP_BACK;
            end else if (pop_front && can_pop_c) begin
                op_c = OP_POP_FRONT;
            end
        end
    end

    // Next-state for the pointers of the addressed channel; indices wrap by truncation.
    always_comb begin
        head_d    = head_q;
        cnt_d     = cnt_q;
        sel_d     = channel_select;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        case (op_c)
            OP_PUSH_BACK: begin
                wr_en_c                  = 1'b1;
                wr_addr_c                = cur_head_c + PTR_BITS'(cur_cnt_c);
                cnt_d[channel_select]    = cur_cnt_c + CNT_BITS'(1);
            end
            OP_PUSH_FRONT: begin
                wr_en_c                  = 1'b1;
                wr_addr_c                = cur_head_c - PTR_BITS'(1);
                head_d[channel_select]   = cur_head_c - PTR_BITS'(1);
                cnt_d[channel_select]    = cur_cnt_c + CNT_BITS'(1);
            end
            OP_POP_BACK: begin
                cnt_d[channel_select]    = cur_cnt_c - CNT_BITS'(1);
            end
            OP_POP_FRONT: begin
                head_d[channel_select]   = cur_head_c + PTR_BITS'(1);
                cnt_d[channel_select]    = cur_cnt_c - CNT_BITS'(1);
            end
            default: begin
            end
        endcase
    end

    // Pointer and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                head_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            sel_q <= '0;
        end else begin
            head_q <= head_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
        end
    end

    // Storage is never cleared. A write landing during reset only touches a slot
    // outside the (reset-empty) occupied range, so it can never become visible.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[channel_select][wr_addr_c] <= data_in;
        end
    end

`ifdef DEQUE_ERR_FLAGS_EN
    logic [CHANNELS-1:0] err_q;
    logic [CHANNELS-1:0] err_d;

    // Sticky flag: raised by any illegal request, even if a lower-priority one executes.
    always_comb begin
        err_d = err_q;
        if (op_ch_valid_c &&
            (((push_back || push_front) && !can_push_c) ||
             ((pop_back || pop_front) && !can_pop_c))) begin
            err_d[channel_select] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    // Status view of the channel held in sel_q; an out-of-range select reads as empty.
    always_comb begin
        s_head_c    = '0;
        s_cnt_c     = '0;
        sel_valid_c = ({1'b0, sel_q} < (CH_BITS + 1)'(CHANNELS));
        if (sel_valid_c) begin
            s_head_c = head_q[sel_q];
            s_cnt_c  = cnt_q[sel_q];
        end
        s_back_c   = s_head_c + PTR_BITS'(s_cnt_c) - PTR_BITS'(1);
        count      = s_cnt_c;
        empty      = (s_cnt_c == '0);
        full       = (s_cnt_c == CNT_BITS'(WORDS));
        data_front = '0;
        data_back  = '0;
        if (!empty) begin
            data_front = mem_q[sel_q][s_head_c];
            data_back  = mem_q[sel_q][s_back_c];
        end
    end

endmodule

// File: tb/tb_multi_deque.sv
// Self-checking bench for multi_deque: table-driven ordering/priority vectors,
// hand-written reset, wrap/full, isolation and error-flag sequences, then
// randomized traffic compared against a queue-based reference model.
module tb_multi_deque;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned WORDS    = 16;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned CH_BITS  = 1;
    localparam int unsigned CNT_BITS = 5;

    logic                clk;
    logic                rst_n;
    logic [CH_BITS-1:0]  channel_select;
    logic                push_front;
    logic                push_back;
    logic                pop_front;
    logic                pop_back;
    logic [WIDTH-1:0]    data_in;
    logic [WIDTH-1:0]    data_front;
    logic [WIDTH-1:0]    data_back;
    logic [CNT_BITS-1:0] count;
    logic                empty;
    logic                full;
`ifdef DEQUE_ERR_FLAGS_EN
    logic [CHANNELS-1:0] err;
`endif

    multi_deque #(
        .WIDTH   (WIDTH),
        .WORDS   (WORDS),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .channel_select(channel_select),
        .push_front    (push_front),
        .push_back     (push_back),
        .pop_front     (pop_front),
        .pop_back      (pop_back),
        .data_in       (data_in),
        .data_front    (data_front),
        .data_back     (data_back),
        .count         (count),
        .empty         (empty),
`ifdef DEQUE_ERR_FLAGS_EN
        .err           (err),
`endif
        .full          (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue per channel, front at index 0.
    logic [WIDTH-1:0]    mq [CHANNELS][$];
    int                  sel_m = 0;
    logic [CHANNELS-1:0] err_m = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(CHANNELS); c++) mq[c].delete();
        sel_m = 0;
        err_m = '0;
    endtask

    // Applies the request rules to the model using the inputs present at the edge.
    task automatic model_edge();
        int ch;
        int sz;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ch = int'(channel_select);
        if (ch < int'(CHANNELS)) begin
            sz = mq[ch].size();
            if (((push_back || push_front) && sz == int'(WORDS)) ||
                ((pop_back || pop_front) && sz == 0))
                err_m[ch] = 1'b1;
            if (push_back && sz < int'(WORDS))       mq[ch].push_back(data_in);
            else if (push_front && sz < int'(WORDS)) mq[ch].push_front(data_in);
            else if (pop_back && sz > 0)             void'(mq[ch].pop_back());
            else if (pop_front && sz > 0)            void'(mq[ch].pop_front());
        end
        sel_m = ch;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input int ch, input logic pb, input logic pf,
                         input logic ppb, input logic ppf, input logic [WIDTH-1:0] din);
        channel_select = CH_BITS'(ch);
        push_back  = pb;
        push_front = pf;
        pop_back   = ppb;
        pop_front  = ppf;
        data_in    = din;
    endtask

    task automatic idle(input int ch);
        drive(ch, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_model(input string tag);
        int sz;
        int ef;
        int eb;
        sz = mq[sel_m].size();
        ef = (sz > 0) ? int'(mq[sel_m][0]) : 0;
        eb = (sz > 0) ? int'(mq[sel_m][sz-1]) : 0;
        chk({tag, ".count"}, int'(count), sz);
        chk({tag, ".empty"}, int'(empty), int'(sz == 0));
        chk({tag, ".full"}, int'(full), int'(sz == int'(WORDS)));
        chk({tag, ".front"}, int'(data_front), ef);
        chk({tag, ".back"}, int'(data_back), eb);
`ifdef DEQUE_ERR_FLAGS_EN
        chk({tag, ".err"}, int'(err), int'(err_m));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int               ch;
        logic             pb;
        logic             pf;
        logic             ppb;
        logic             ppf;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] e_front;
        logic [WIDTH-1:0] e_back;
        int               e_count;
        logic             e_empty;
        logic             e_full;
    } vec_t;

    vec_t tbl [11];

    int p_push;

    initial begin
        rst_n = 1'b0;
        idle(0);

        // Ordering and priority on ch0, expected values worked out by hand.
        tbl[0]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h11, 8'h11, 1, 1'b0, 1'b0};
        tbl[1]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h11, 8'h22, 2, 1'b0, 1'b0};
        tbl[2]  = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h33, 8'h22, 3, 1'b0, 1'b0};
        tbl[3]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 8'h11, 2, 1'b0, 1'b0};
        tbl[4]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 8'h11, 1, 1'b0, 1'b0};
        tbl[5]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0};
        tbl[6]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0};
        tbl[7]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 1, 1'b0, 1'b0};
        tbl[8]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h01, 8'h02, 2, 1'b0, 1'b0};
        tbl[9]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h01, 8'h55, 3, 1'b0, 1'b0};
        tbl[10] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'h02, 2, 1'b0, 1'b0};

        // Reset state.
        model_reset();
        tick();
        tick();
        chk("reset.empty", int'(empty), 1);
        chk("reset.full", int'(full), 0);
        chk("reset.count", int'(count), 0);
        chk("reset.front", int'(data_front), 0);
        chk("reset.back", int'(data_back), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ch, tbl[i].pb, tbl[i].pf, tbl[i].ppb, tbl[i].ppf, tbl[i].din);
            tick();
            chk($sformatf("vec%0d.front", i), int'(data_front), int'(tbl[i].e_front));
            chk($sformatf("vec%0d.back", i), int'(data_back), int'(tbl[i].e_back));
            chk($sformatf("vec%0d.count", i), int'(count), tbl[i].e_count);
            chk($sformatf("vec%0d.empty", i), int'(empty), int'(tbl[i].e_empty));
            chk($sformatf("vec%0d.full", i), int'(full), int'(tbl[i].e_full));
        end

        // Asynchronous reset in the middle of traffic clears state without a clock edge.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hA0 + i));
            tick();
        end
        chk("midrst.pre_count", int'(count), 3);
        idle(0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.empty", int'(empty), 1);
        chk("midrst.count", int'(count), 0);
        chk("midrst.front", int'(data_front), 0);
        tick();
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        chk("midrst.pop_count", int'(count), 0);
        chk("midrst.pop_empty", int'(empty), 1);

        // Wrap-around and full behaviour.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
            tick();
        end
        chk("wrap.full", int'(full), 1);
        chk("wrap.count", int'(count), 16);
        chk("wrap.front", int'(data_front), 8'h0F);
        chk("wrap.back", int'(data_back), 8'h00);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        tick();
        chk("wrap.push17_count", int'(count), 16);
        chk("wrap.push17_back", int'(data_back), 8'h00);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        tick();
        chk("wrap.skip_count", int'(count), 15);
        chk("wrap.skip_front", int'(data_front), 8'h0E);
        chk("wrap.skip_full", int'(full), 0);

        // Channel isolation and one-cycle select latency.
        do_reset();
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        tick();
        chk("iso.ch1_count", int'(count), 1);
        idle(0);
        #1;
        chk("iso.latency_count", int'(count), 1);
        tick();
        chk("iso.ch0_empty", int'(empty), 1);
        chk("iso.ch0_front", int'(data_front), 0);
        idle(1);
        tick();
        chk("iso.ch1_front", int'(data_front), 8'hAA);
        chk("iso.ch1_count", int'(count), 1);

`ifdef DEQUE_ERR_FLAGS_EN
        // Sticky error flag.
        do_reset();
        drive(1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        chk("err.set", int'(err), 2);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
            tick();
        end
        chk("err.sticky", int'(err), 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("err.reset", int'(err), 0);
        tick();
        rst_n = 1'b1;
`endif

        // Randomized traffic against the queue model, alternating push- and pop-heavy phases.
        do_reset();
        p_push = 70;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc % 250) == 0) p_push = (p_push == 70) ? 30 : 70;
            drive(int'($urandom_range(0, CHANNELS - 1)),
                  1'($urandom_range(0, 99) < p_push),
                  1'($urandom_range(0, 99) < p_push / 2),
                  1'($urandom_range(0, 99) < (100 - p_push) / 2),
                  1'($urandom_range(0, 99) < (100 - p_push)),
                  8'($urandom));
            tick();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
